// File: rtl/i2c_fifo_pkg.sv
// rtl/i2c_fifo_pkg.sv - shared constants and Gray-code helpers for the I2C async FIFO
package i2c_fifo_pkg;

  localparam int DEF_WIDTH     = 10;
  localparam int DEF_ADDR_BITS = 2;
  // widest pointer the helpers handle: ADDR_BITS up to 8 plus the wrap bit
  localparam int PTR_MAX       = 9;

  function automatic logic [PTR_MAX-1:0] bin2gray(input logic [PTR_MAX-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [PTR_MAX-1:0] gray2bin(input logic [PTR_MAX-1:0] g);
    logic [PTR_MAX-1:0] b;
    b[PTR_MAX-1] = g[PTR_MAX-1];
    for (int i = PTR_MAX - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/i2c_fifo_ptr.sv
// rtl/i2c_fifo_ptr.sv - binary plus registered Gray pointer with count enable
module i2c_fifo_ptr
  import i2c_fifo_pkg::*;
#(
  parameter int BITS = DEF_ADDR_BITS + 1
) (
  input  logic            clk,
  input  logic            rst_an,
  input  logic            inc,
  output logic [BITS-1:0] bin,
  output logic [BITS-1:0] gray
);

  logic [BITS-1:0] bin_next;

  assign bin_next = bin + BITS'(inc);

  // Gray is registered so only glitch-free single-bit changes leave this domain
  always_ff @(posedge clk or negedge rst_an) begin
    if (!rst_an) begin
      bin  <= '0;
      gray <= '0;
    end else if (inc) begin
      bin  <= bin_next;
      gray <= BITS'(bin2gray(PTR_MAX'(bin_next)));
    end
  end

endmodule

// File: rtl/i2c_async_fifo.sv
// rtl/i2c_async_fifo.sv - dual-clock show-ahead FIFO with levels, thresholds and sticky errors
module i2c_async_fifo
  import i2c_fifo_pkg::*;
#(
  parameter int WIDTH         = DEF_WIDTH,
  parameter int ADDR_BITS     = DEF_ADDR_BITS,
  parameter int SYNC_STAGES   = 2,
  parameter int AFULL_THRESH  = (2 ** ADDR_BITS) - 1,
  parameter int AEMPTY_THRESH = 1
) (
  input  logic                 wr_clk,
  input  logic                 rd_clk,
  input  logic                 rst_an,
  input  logic                 wr_n,
  input  logic [WIDTH-1:0]     di,
  output logic                 full,
  output logic                 afull,
  output logic [ADDR_BITS:0]   wr_level,
  output logic                 ovf,
  input  logic                 clr_ovf,
  input  logic                 rd_n,
  output logic [WIDTH-1:0]     dout,
  output logic                 empty,
  output logic                 aempty,
  output logic [ADDR_BITS:0]   rd_level,
  output logic                 udf,
  input  logic                 clr_udf
);

  localparam int DEPTH = 2 ** ADDR_BITS;
  localparam int PW    = ADDR_BITS + 1;

  logic [PW-1:0]    wbin, wgray, rbin, rgray;
  logic [PW-1:0]    wbin_sync, rbin_sync;
  logic [PW-1:0]    rgray_sync [SYNC_STAGES];
  logic [PW-1:0]    wgray_sync [SYNC_STAGES];
  logic [WIDTH-1:0] mem [DEPTH];
  logic             wr_en, rd_en;

  assign wr_en = !wr_n && !full;
  assign rd_en = !rd_n && !empty;

  i2c_fifo_ptr #(.BITS(PW)) u_wr_ptr (
    .clk(wr_clk), .rst_an(rst_an), .inc(wr_en), .bin(wbin), .gray(wgray)
  );

  i2c_fifo_ptr #(.BITS(PW)) u_rd_ptr (
    .clk(rd_clk), .rst_an(rst_an), .inc(rd_en), .bin(rbin), .gray(rgray)
  );

  for (genvar s = 0; s < SYNC_STAGES; s++) begin : g_sync
    if (s == 0) begin : g_first
      always_ff @(posedge wr_clk or negedge rst_an) begin
        if (!rst_an) rgray_sync[0] <= '0;
        else         rgray_sync[0] <= rgray;
      end
      always_ff @(posedge rd_clk or negedge rst_an) begin
        if (!rst_an) wgray_sync[0] <= '0;
        else         wgray_sync[0] <= wgray;
      end
    end else begin : g_next
      always_ff @(posedge wr_clk or negedge rst_an) begin
        if (!rst_an) rgray_sync[s] <= '0;
        else         rgray_sync[s] <= rgray_sync[s-1];
      end
      always_ff @(posedge rd_clk or negedge rst_an) begin
        if (!rst_an) wgray_sync[s] <= '0;
        else         wgray_sync[s] <= wgray_sync[s-1];
      end
    end
  end

  assign rbin_sync = PW'(gray2bin(PTR_MAX'(rgray_sync[SYNC_STAGES-1])));
  assign wbin_sync = PW'(gray2bin(PTR_MAX'(wgray_sync[SYNC_STAGES-1])));

  // levels rely on modulo-2^PW subtraction across the pointer wrap
  assign wr_level = wbin - rbin_sync;
  assign rd_level = wbin_sync - rbin;
  assign full     = (wr_level == PW'(DEPTH));
  assign empty    = (rd_level == '0);
  assign afull    = (int'(wr_level) >= AFULL_THRESH);
  assign aempty   = (int'(rd_level) <= AEMPTY_THRESH);

  always_ff @(posedge wr_clk) begin
    if (wr_en) mem[wbin[ADDR_BITS-1:0]] <= di;
  end

  assign dout = empty ? '0 : mem[rbin[ADDR_BITS-1:0]];

  always_ff @(posedge wr_clk or negedge rst_an) begin
    if (!rst_an)              ovf <= 1'b0;
    else if (!wr_n && full)   ovf <= 1'b1;
    else if (clr_ovf)         ovf <= 1'b0;
  end

  always_ff @(posedge rd_clk or negedge rst_an) begin
    if (!rst_an)              udf <= 1'b0;
    else if (!rd_n && empty)  udf <= 1'b1;
    else if (clr_udf)         udf <= 1'b0;
  end

endmodule

// File: tb/tb_i2c_async_fifo.sv
// tb/tb_i2c_async_fifo.sv - self-checking bench for i2c_async_fifo
`timescale 1ns/100ps
module tb_i2c_async_fifo;

  localparam int WIDTH = 10;
  localparam int DEPTH = 4;
  localparam int PW    = 3;

  logic wr_clk = 1'b0, rd_clk = 1'b0, rst_an = 1'b0;
  logic wr_n = 1'b1, rd_n = 1'b1, clr_ovf = 1'b0, clr_udf = 1'b0;
  logic [WIDTH-1:0] di = '0;
  logic [WIDTH-1:0] dout;
  logic full, afull, ovf, empty, aempty, udf;
  logic [PW-1:0] wr_level, rd_level;

  i2c_async_fifo #(.WIDTH(10), .ADDR_BITS(2), .SYNC_STAGES(2)) dut (
    .wr_clk(wr_clk), .rd_clk(rd_clk), .rst_an(rst_an),
    .wr_n(wr_n), .di(di), .full(full), .afull(afull), .wr_level(wr_level),
    .ovf(ovf), .clr_ovf(clr_ovf),
    .rd_n(rd_n), .dout(dout), .empty(empty), .aempty(aempty), .rd_level(rd_level),
    .udf(udf), .clr_udf(clr_udf)
  );

  always #5 wr_clk = ~wr_clk;
  initial begin
    #3;
    forever #18.5 rd_clk = ~rd_clk;
  end

  // model: cumulative accepted writes/reads plus per-domain history of the other count
  int checks = 0, errors = 0;
  int wcnt = 0, rcnt = 0;
  int wneg_n = 0, rneg_n = 0;
  int rh [8];
  int wh [8];
  bit m_ovf = 1'b0, m_udf = 1'b0;
  bit cmp_on = 1'b0;
  logic [WIDTH-1:0] data_log [256];

  bit ok, ok_w, ok_r;
  logic [WIDTH-1:0] d, d_r;
  int n_w, n_r, cyc_w, cyc_r;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_rng(input string name, input logic [31:0] act, input int lo, input int hi);
    checks++;
    if ($isunknown(act) || int'(act) < lo || int'(act) > hi) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d..%0d at %0t", name, act, lo, hi, $time);
    end
  endtask

  // true occupancy is the floor; anything unseen for 5+ edges bounds the pessimistic side
  function automatic int wr_lo(); return wcnt - rcnt; endfunction
  function automatic int wr_hi(); return wcnt - rh[(wneg_n + 2) % 8]; endfunction
  function automatic int rd_hi(); return wcnt - rcnt; endfunction
  function automatic int rd_lo();
    int v;
    v = wh[(rneg_n + 2) % 8] - rcnt;
    return (v < 0) ? 0 : v;
  endfunction

  always @(negedge wr_clk) begin
    if (cmp_on) begin
      rh[wneg_n % 8] = rcnt;
      wneg_n++;
      chk_rng("wr_level", 32'(wr_level), wr_lo(), wr_hi());
      chk("full", 32'(full), 32'(wr_level == 3'(DEPTH)));
      chk("afull", 32'(afull), 32'(wr_level >= 3'd3));
      chk("ovf", 32'(ovf), 32'(m_ovf));
    end
  end

  always @(negedge rd_clk) begin
    if (cmp_on) begin
      wh[rneg_n % 8] = wcnt;
      rneg_n++;
      chk_rng("rd_level", 32'(rd_level), rd_lo(), rd_hi());
      chk("empty", 32'(empty), 32'(rd_level == 3'd0));
      chk("aempty", 32'(aempty), 32'(rd_level <= 3'd1));
      chk("dout", 32'(dout), empty ? 32'd0 : 32'(data_log[rcnt % 256]));
      chk("udf", 32'(udf), 32'(m_udf));
    end
  end

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      rh[i] = 0;
      wh[i] = 0;
    end
    wcnt = 0; rcnt = 0; wneg_n = 0; rneg_n = 0;
    m_ovf = 1'b0; m_udf = 1'b0;
  endtask

  task automatic wr_sync(); @(posedge wr_clk); #1; endtask
  task automatic rd_sync(); @(posedge rd_clk); #1; endtask
  task automatic settle(); repeat (8) @(posedge rd_clk); endtask

  // waits until acceptance is certain either way, then strobes once
  task automatic wr_word(input logic [WIDTH-1:0] wd, output bit acc);
    int tries;
    tries = 0;
    acc = 1'b0;
    while (wr_hi() >= DEPTH && wr_lo() < DEPTH && tries < 100) begin
      @(posedge wr_clk); #1;
      tries++;
    end
    if (tries >= 100) begin
      checks++; errors++;
      $display("FAIL wr_timeout: got no decision, want one within 100 cycles");
    end else begin
      di = wd;
      wr_n = 1'b0;
      @(posedge wr_clk);
      if (wr_lo() >= DEPTH) m_ovf = 1'b1;
      else begin
        data_log[wcnt % 256] = wd;
        wcnt++;
        acc = 1'b1;
      end
      #1 wr_n = 1'b1;
    end
  endtask

  task automatic rd_word(output bit acc, output logic [WIDTH-1:0] rdata);
    int tries;
    tries = 0;
    acc = 1'b0;
    rdata = '0;
    while (rd_lo() <= 0 && rd_hi() > 0 && tries < 100) begin
      @(posedge rd_clk); #1;
      tries++;
    end
    if (tries >= 100) begin
      checks++; errors++;
      $display("FAIL rd_timeout: got no decision, want one within 100 cycles");
    end else begin
      rdata = dout;
      rd_n = 1'b0;
      @(posedge rd_clk);
      if (rd_hi() == 0) m_udf = 1'b1;
      else begin
        rcnt++;
        acc = 1'b1;
      end
      #1 rd_n = 1'b1;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, want end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    #23 rst_an = 1'b1;
    #1;
    chk("rst_full", 32'(full), 0);
    chk("rst_afull", 32'(afull), 0);
    chk("rst_wr_level", 32'(wr_level), 0);
    chk("rst_ovf", 32'(ovf), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_aempty", 32'(aempty), 1);
    chk("rst_rd_level", 32'(rd_level), 0);
    chk("rst_udf", 32'(udf), 0);
    chk("rst_dout", 32'(dout), 0);
    cmp_on = 1'b1;

    // single word
    wr_sync();
    wr_word(10'h2A5, ok);
    chk("single_acc", 32'(ok), 1);
    chk("single_wr_level", 32'(wr_level), 1);
    rd_sync();
    chk("single_empty_edge1", 32'(empty), 1);
    repeat (2) @(posedge rd_clk);
    #1;
    chk("single_empty_edge3", 32'(empty), 0);
    chk("single_dout", 32'(dout), 32'h2A5);
    rd_word(ok, d);
    chk("single_rd_data", 32'(d), 32'h2A5);
    chk("single_empty_after", 32'(empty), 1);
    chk("single_dout_after", 32'(dout), 0);

    // fill and overflow
    settle();
    wr_sync();
    for (int i = 1; i <= 5; i++) begin
      wr_word(10'(i), ok);
      if (i == 2) chk("fill_afull_2", 32'(afull), 0);
      if (i == 3) begin
        chk("fill_afull_3", 32'(afull), 1);
        chk("fill_full_3", 32'(full), 0);
      end
      if (i == 4) begin
        chk("fill_full_4", 32'(full), 1);
        chk("fill_level_4", 32'(wr_level), 4);
      end
      if (i == 5) begin
        chk("fill_drop", 32'(ok), 0);
        chk("fill_ovf", 32'(ovf), 1);
        chk("fill_level_5", 32'(wr_level), 4);
      end
    end
    clr_ovf = 1'b1;
    @(posedge wr_clk);
    m_ovf = 1'b0;
    #1 clr_ovf = 1'b0;
    chk("clr_ovf", 32'(ovf), 0);

    // drain and underflow
    settle();
    rd_sync();
    chk("drain_level_4", 32'(rd_level), 4);
    for (int i = 1; i <= 5; i++) begin
      rd_word(ok, d);
      if (i <= 4) begin
        chk("drain_acc", 32'(ok), 1);
        chk("drain_data", 32'(d), 32'(i));
      end
      if (i == 2) begin
        chk("drain_level_2", 32'(rd_level), 2);
        chk("drain_aempty_2", 32'(aempty), 0);
      end
      if (i == 3) begin
        chk("drain_level_1", 32'(rd_level), 1);
        chk("drain_aempty_1", 32'(aempty), 1);
      end
      if (i == 5) begin
        chk("drain_reject", 32'(ok), 0);
        chk("drain_udf", 32'(udf), 1);
        chk("drain_dout", 32'(dout), 0);
      end
    end
    clr_udf = 1'b1;
    @(posedge rd_clk);
    m_udf = 1'b0;
    #1 clr_udf = 1'b0;
    chk("clr_udf", 32'(udf), 0);

    // streaming across the pointer wrap
    settle();
    wr_sync();
    rd_sync();
    fork
      begin
        n_w = 0;
        cyc_w = 0;
        while (n_w < 20 && cyc_w < 3000) begin
          if ($urandom_range(0, 3) != 0 && wr_hi() < DEPTH) begin
            wr_word(10'h100 + 10'(n_w), ok_w);
            if (ok_w) n_w++;
          end else begin
            @(posedge wr_clk); #1;
          end
          cyc_w++;
        end
        chk("wrap_writes", 32'(n_w), 20);
      end
      begin
        n_r = 0;
        cyc_r = 0;
        while (n_r < 20 && cyc_r < 1500) begin
          if ($urandom_range(0, 2) != 0 && rd_lo() > 0) begin
            rd_word(ok_r, d_r);
            if (ok_r) begin
              chk("wrap_order", 32'(d_r), 32'h100 + 32'(n_r));
              n_r++;
            end
          end else begin
            @(posedge rd_clk); #1;
          end
          cyc_r++;
        end
        chk("wrap_reads", 32'(n_r), 20);
      end
    join
    chk("wrap_no_ovf", 32'(ovf), 0);
    chk("wrap_no_udf", 32'(udf), 0);

    // reset mid-stream
    settle();
    wr_sync();
    for (int i = 0; i < 3; i++) wr_word(10'h050 + 10'(i), ok);
    repeat (6) @(posedge rd_clk);
    #2;
    chk("pre_rst_level", 32'(rd_level), 3);
    cmp_on = 1'b0;
    rst_an = 1'b0;
    #4;
    model_reset();
    rst_an = 1'b1;
    #1;
    chk("mid_rst_empty", 32'(empty), 1);
    chk("mid_rst_wr_level", 32'(wr_level), 0);
    chk("mid_rst_dout", 32'(dout), 0);
    cmp_on = 1'b1;
    wr_sync();
    wr_word(10'h3FF, ok);
    settle();
    rd_sync();
    chk("post_rst_dout", 32'(dout), 32'h3FF);
    rd_word(ok, d);
    chk("post_rst_data", 32'(d), 32'h3FF);
    chk("post_rst_empty", 32'(empty), 1);
    repeat (4) @(posedge rd_clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
